b_bqt_seq: RTL and testbench
============================

// Module: b_bqt_seq
// PURPOSE
//  Sequencer for the B_BQT bias+tanh-quantize datapath in the LSTM gate pipe.
//  Per hidden unit: accepts four 32-bit partial inner products (R, Rtemp1..3) from the MAC array,
//  fetches the unit's 8-bit bias from bias SRAM, drives comb_ctrl=B_BQT for one eval cycle,
//  and captures the saturated 8-bit result into a valid/ready output stream. Repeats for NUM_UNITS units.
// PARAMETERS
//  NUM_UNITS  64     units processed per start (1..2**ADDR_W)
//  ADDR_W     6      bias address / unit index width
//  CODE_EVAL  5'd6   comb_ctrl value selecting B_BQT
//  CODE_IDLE  5'd0   comb_ctrl value outside eval
// PORTS
//  clk            in   1      clock, rising edge
//  resetn         in   1      asynchronous active-low reset
//  start_i        in   1      pulse: begin a NUM_UNITS pass (ignored while busy_o=1)
//  psum_valid_i   in   1      partial-sum beat valid
//  psum_ready_o   out  1      partial-sum beat accepted when valid&ready
//  psum_i         in   32     signed partial sum; beats 0..3 = R, Rtemp1, Rtemp2, Rtemp3
//  bias_rd_o      out  1      bias SRAM read strobe
//  bias_addr_o    out  ADDR_W bias address (= current unit index)
//  bias_data_i    in   8      bias read data, valid exactly 1 cycle after bias_rd_o
//  comb_ctrl_o    out  5      to datapath comb_ctrl
//  inpdt_r_o, inpdt_t1_o, inpdt_t2_o, inpdt_t3_o  out 32 each  operand registers to datapath
//  bias_buf_o     out  8      bias operand register to datapath
//  b_sat_i        in   8      datapath result B_sat_BQT (combinational from operands)
//  out_valid_o    out  1      result valid
//  out_ready_i    in   1      downstream ready
//  out_data_o     out  8      quantized tanh-domain result
//  out_idx_o      out  ADDR_W unit index of out_data_o
//  busy_o         out  1      high from start accept until DONE exits
//  done_o         out  1      one-cycle pulse after last unit's result handed off
// BEHAVIOUR
//  Reset: all outputs 0; comb_ctrl_o=CODE_IDLE; operand regs, unit cnt, beat cnt = 0; FSM=IDLE.
//  FSM IDLE -> LOAD (start_i) ; LOAD -> EVAL (4th beat accepted and bias captured) ;
//      EVAL -> OUT (always, 1 cycle) ; OUT -> LOAD (handshake, unit<NUM_UNITS-1, unit++) ;
//      OUT -> DONE (handshake, last unit) ; DONE -> IDLE (1 cycle, done_o=1).
//  LOAD: psum_ready_o=1; beat k (0..3) written to operand k on valid&ready; beat cnt wraps 3->0.
//      bias_rd_o=1 only on first cycle of LOAD, bias_addr_o=unit; bias_buf_o loaded next cycle.
//      LOAD lasts >=4 cycles, so bias always captured before EVAL; no stall on bias path.
//  EVAL: psum_ready_o=0; comb_ctrl_o=CODE_EVAL (registered, high exactly this cycle);
//      b_sat_i sampled at end of EVAL into out_data_o; out_idx_o=unit.
//  OUT: out_valid_o=1, data/idx stable until out_valid_o&out_ready_i; psum_ready_o=0.
//  No arithmetic in this block; operands passed unmodified (signed 32b, unsigned 8b bias).
//  Throughput with out_ready_i=1 and continuous psum: 6 cycles/unit (4 LOAD+EVAL+OUT).
//  start_i while busy_o=1: ignored, no state change. start_i in DONE cycle: ignored.
//  psum_valid_i outside LOAD: not accepted (ready=0), operands unchanged.
//  resetn low mid-pass: immediate return to reset state; partial unit discarded, no done_o.
//  NUM_UNITS=1: single LOAD/EVAL/OUT then DONE. Unit cnt wraps only via IDLE (cleared on start).
// TESTING (bench instantiates B_BQT with default params driven by this block)
//  T1 start, psums 4096x4, bias 0, ready=1 -> out_data=176, idx=0, comb_ctrl=6 for 1 cycle.
//  T2 psums 0x4, bias 255 -> out_data=175; bias_rd_o seen once, addr=unit index.
//  T3 psums 250000x4 -> 255 (sat high); psums -250000x4 -> 0 (sat low).
//  T4 NUM_UNITS=4, out_ready low 10 cycles on unit 1 -> data/idx held, no psum accepted, idx 0..3 in order, done_o once.
//  T5 start_i pulsed mid-pass and psum_valid during EVAL/OUT -> ignored; results unchanged.
//  T6 resetn low after 2 beats of unit 2 -> all outputs 0 async; new start restarts at idx 0.

Source files
------------

// File: rtl/b_bqt_seq.sv
// Sequencer for the B_BQT bias+tanh-quantize datapath. It collects four partial sums per unit and
// fetches the unit's bias. It then pulses comb_ctrl for one eval cycle and streams out the saturated result.
module b_bqt_seq #(
   parameter int unsigned NUM_UNITS = 64,
   parameter int unsigned ADDR_W    = 6,
   parameter logic [4:0]  CODE_EVAL = 5'd6,
   parameter logic [4:0]  CODE_IDLE = 5'd0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start_i,
   input  logic              psum_valid_i,
   output logic              psum_ready_o,
   input  logic [31:0]       psum_i,
   output logic              bias_rd_o,
   output logic [ADDR_W-1:0] bias_addr_o,
   input  logic [7:0]        bias_data_i,
   output logic [4:0]        comb_ctrl_o,
   output logic [31:0]       inpdt_r_o,
   output logic [31:0]       inpdt_t1_o,
   output logic [31:0]       inpdt_t2_o,
   output logic [31:0]       inpdt_t3_o,
   output logic [7:0]        bias_buf_o,
   input  logic [7:0]        b_sat_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [7:0]        out_data_o,
   output logic [ADDR_W-1:0] out_idx_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int unsigned PSUM_W = 32;
   localparam int unsigned BIAS_W = 8;
   localparam int unsigned RES_W  = 8;
   localparam int unsigned CTRL_W = 5;
   localparam int unsigned BEAT_W = 2;
   localparam logic [ADDR_W-1:0] LAST_UNIT = ADDR_W'(NUM_UNITS - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(3);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_EVAL,
      S_OUT,
      S_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [ADDR_W-1:0]        unit_q, unit_d;
   logic [BEAT_W-1:0]        beat_q, beat_d;
   logic [3:0][PSUM_W-1:0]   opnd_q, opnd_d;
   logic [BIAS_W-1:0]        bias_buf_q, bias_buf_d;
   logic                     bias_pend_q, bias_pend_d;
   logic                     psum_ready_q, psum_ready_d;
   logic                     bias_rd_q, bias_rd_d;
   logic [ADDR_W-1:0]        bias_addr_q, bias_addr_d;
   logic [CTRL_W-1:0]        comb_ctrl_q, comb_ctrl_d;
   logic                     out_valid_q, out_valid_d;
   logic [RES_W-1:0]         out_data_q, out_data_d;
   logic [ADDR_W-1:0]        out_idx_q, out_idx_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     psum_fire;
   logic                     out_fire;

   // Next-state and registered-output logic; outputs follow the state being entered.
   always_comb begin
      state_d    = state_q;
      unit_d     = unit_q;
      beat_d     = beat_q;
      opnd_d     = opnd_q;
      bias_buf_d = bias_buf_q;
      out_data_d = out_data_q;
      out_idx_d  = out_idx_q;
      psum_fire  = psum_valid_i & psum_ready_q;
      out_fire   = out_valid_q & out_ready_i;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_LOAD;
               unit_d  = '0;
               beat_d  = '0;
            end
         end
         S_LOAD: begin
            if (psum_fire) begin
               opnd_d[beat_q] = psum_i;
               beat_d         = beat_q + BEAT_W'(1);
               if (beat_q == LAST_BEAT) begin
                  state_d = S_EVAL;
               end
            end
         end
         S_EVAL: begin
            out_data_d = b_sat_i;
            out_idx_d  = unit_q;
            state_d    = S_OUT;
         end
         S_OUT: begin
            if (out_fire) begin
               if (unit_q == LAST_UNIT) begin
                  state_d = S_DONE;
               end else begin
                  unit_d  = unit_q + ADDR_W'(1);
                  state_d = S_LOAD;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Bias SRAM returns data one cycle after the read strobe.
      if (bias_pend_q) begin
         bias_buf_d = bias_data_i;
      end

      psum_ready_d = (state_d == S_LOAD);
      bias_rd_d    = (state_d == S_LOAD) && (state_q != S_LOAD);
      bias_addr_d  = unit_d;
      bias_pend_d  = bias_rd_q;
      comb_ctrl_d  = (state_d == S_EVAL) ? CODE_EVAL : CODE_IDLE;
      out_valid_d  = (state_d == S_OUT);
      busy_d       = (state_d != S_IDLE);
      done_d       = (state_d == S_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         unit_q       <= '0;
         beat_q       <= '0;
         opnd_q       <= '0;
         bias_buf_q   <= '0;
         bias_pend_q  <= 1'b0;
         psum_ready_q <= 1'b0;
         bias_rd_q    <= 1'b0;
         bias_addr_q  <= '0;
         comb_ctrl_q  <= CODE_IDLE;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_idx_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         unit_q       <= unit_d;
         beat_q       <= beat_d;
         opnd_q       <= opnd_d;
         bias_buf_q   <= bias_buf_d;
         bias_pend_q  <= bias_pend_d;
         psum_ready_q <= psum_ready_d;
         bias_rd_q    <= bias_rd_d;
         bias_addr_q  <= bias_addr_d;
         comb_ctrl_q  <= comb_ctrl_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_idx_q    <= out_idx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign psum_ready_o = psum_ready_q;
   assign bias_rd_o    = bias_rd_q;
   assign bias_addr_o  = bias_addr_q;
   assign comb_ctrl_o  = comb_ctrl_q;
   assign inpdt_r_o    = opnd_q[0];
   assign inpdt_t1_o   = opnd_q[1];
   assign inpdt_t2_o   = opnd_q[2];
   assign inpdt_t3_o   = opnd_q[3];
   assign bias_buf_o   = bias_buf_q;
   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign out_idx_o    = out_idx_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_b_bqt_seq.sv
// Bench for b_bqt_seq: stand-in B_BQT datapath, bias SRAM model and directed/random passes
// checked against a unit-level reference of the expected results and handshakes.
module tb_b_bqt_seq;

   localparam int unsigned NU = 4;
   localparam int unsigned AW = 6;

   logic          clk;
   logic          resetn;
   logic          start_i;
   logic          psum_valid_i;
   logic          psum_ready_o;
   logic [31:0]   psum_i;
   logic          bias_rd_o;
   logic [AW-1:0] bias_addr_o;
   logic [7:0]    bias_data_i;
   logic [4:0]    comb_ctrl_o;
   logic [31:0]   inpdt_r_o, inpdt_t1_o, inpdt_t2_o, inpdt_t3_o;
   logic [7:0]    bias_buf_o;
   logic [7:0]    b_sat_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [7:0]    out_data_o;
   logic [AW-1:0] out_idx_o;
   logic          busy_o;
   logic          done_o;

   logic [7:0]  bias_mem [2**AW];
   logic [31:0] ps [NU][4];
   int n_vec = 0;
   int n_err = 0;
   int acc_cnt = 0;
   int done_cnt = 0;
   int rd_q [$];

   b_bqt_seq #(.NUM_UNITS(NU), .ADDR_W(AW)) dut (
      .clk(clk), .resetn(resetn), .start_i(start_i),
      .psum_valid_i(psum_valid_i), .psum_ready_o(psum_ready_o), .psum_i(psum_i),
      .bias_rd_o(bias_rd_o), .bias_addr_o(bias_addr_o), .bias_data_i(bias_data_i),
      .comb_ctrl_o(comb_ctrl_o),
      .inpdt_r_o(inpdt_r_o), .inpdt_t1_o(inpdt_t1_o), .inpdt_t2_o(inpdt_t2_o), .inpdt_t3_o(inpdt_t3_o),
      .bias_buf_o(bias_buf_o), .b_sat_i(b_sat_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
      .out_idx_o(out_idx_o), .busy_o(busy_o), .done_o(done_o)
   );

   // Stand-in for B_BQT: offset 176 plus signed bias plus scaled sum, saturated to 0..255.
   function automatic logic [7:0] bqt(input logic signed [31:0] r, t1, t2, t3, input logic [7:0] b);
      longint s, v;
      s = longint'(r) + longint'(t1) + longint'(t2) + longint'(t3);
      v = 176 + longint'($signed(b)) + (s / 16385) * 8;
      if (v < 0) v = 0;
      else if (v > 255) v = 255;
      return 8'(v);
   endfunction

   assign b_sat_i = bqt(inpdt_r_o, inpdt_t1_o, inpdt_t2_o, inpdt_t3_o, bias_buf_o);

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bias_rd_o) begin
         bias_data_i <= bias_mem[bias_addr_o];
         rd_q.push_back(int'(bias_addr_o));
      end
      if (psum_valid_i && psum_ready_o) acc_cnt++;
      if (done_o) done_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_psum_ready"}, psum_ready_o, 0);
      chk({tag, "_bias_rd"}, bias_rd_o, 0);
      chk({tag, "_bias_addr"}, bias_addr_o, 0);
      chk({tag, "_comb_ctrl"}, comb_ctrl_o, 0);
      chk({tag, "_opnd_r"}, inpdt_r_o, 0);
      chk({tag, "_opnd_t1"}, inpdt_t1_o, 0);
      chk({tag, "_opnd_t2"}, inpdt_t2_o, 0);
      chk({tag, "_opnd_t3"}, inpdt_t3_o, 0);
      chk({tag, "_bias_buf"}, bias_buf_o, 0);
      chk({tag, "_out_valid"}, out_valid_o, 0);
      chk({tag, "_out_data"}, out_data_o, 0);
      chk({tag, "_out_idx"}, out_idx_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
   endtask

   task automatic send_beats(input int u, input int nbeats);
      for (int k = 0; k < nbeats; k++) begin
         int w;
         psum_valid_i = 1'b1;
         psum_i       = ps[u][k];
         w = 0;
         while (!psum_ready_o && w < 50) begin
            @(negedge clk);
            w++;
         end
         if (w >= 50) chk("psum_ready_timeout", 0, 1);
         @(negedge clk);
      end
      psum_valid_i = 1'b0;
   endtask

   task automatic run_unit(input int u, input bit stall, input bit poke);
      int a0, evals, cyc;
      logic [7:0] exp_d;
      a0 = acc_cnt;
      out_ready_i = !stall;
      send_beats(u, 4);
      chk("bias_rd_count", rd_q.size(), 1);
      if (rd_q.size() > 0) chk("bias_rd_addr", rd_q.pop_front(), u);
      if (poke) begin
         psum_valid_i = 1'b1;
         psum_i       = 32'hDEAD_BEEF;
         start_i      = 1'b1;
      end
      evals = 0;
      cyc   = 0;
      while (!out_valid_o && cyc < 20) begin
         if (comb_ctrl_o == 5'd6) begin
            evals++;
            chk("eval_opnd_r", inpdt_r_o, ps[u][0]);
            chk("eval_opnd_t1", inpdt_t1_o, ps[u][1]);
            chk("eval_opnd_t2", inpdt_t2_o, ps[u][2]);
            chk("eval_opnd_t3", inpdt_t3_o, ps[u][3]);
            chk("eval_bias_buf", bias_buf_o, bias_mem[u]);
         end
         @(negedge clk);
         cyc++;
      end
      exp_d = bqt(ps[u][0], ps[u][1], ps[u][2], ps[u][3], bias_mem[u]);
      chk("out_valid_seen", out_valid_o, 1);
      chk("eval_cycles", evals, 1);
      chk("out_data", out_data_o, exp_d);
      chk("out_idx", out_idx_o, u);
      chk("psum_ready_in_out", psum_ready_o, 0);
      chk("comb_ctrl_in_out", comb_ctrl_o, 0);
      if (stall) begin
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid_o, 1);
            chk("hold_data", out_data_o, exp_d);
            chk("hold_idx", out_idx_o, u);
         end
         out_ready_i = 1'b1;
      end
      psum_valid_i = 1'b0;
      start_i      = 1'b0;
      @(negedge clk);
      chk("psum_accepts", acc_cnt - a0, 4);
   endtask

   task automatic run_pass(input int stall_u, input bit poke);
      int d0;
      d0 = done_cnt;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("busy_after_start", busy_o, 1);
      for (int u = 0; u < NU; u++) run_unit(u, (u == stall_u), poke);
      chk("done_pulse", done_o, 1);
      chk("busy_in_done", busy_o, 1);
      if (poke) start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("done_low", done_o, 0);
      chk("busy_idle", busy_o, 0);
      chk("done_count", done_cnt - d0, 1);
      @(negedge clk);
      chk("start_in_done_ignored", busy_o, 0);
   endtask

   task automatic randomize_units();
      for (int u = 0; u < NU; u++) begin
         bias_mem[u] = 8'($urandom_range(0, 255));
         for (int k = 0; k < 4; k++) ps[u][k] = 32'($urandom_range(0, 200000)) - 32'd100000;
      end
   endtask

   initial begin
      int d0;
      clk          = 1'b0;
      resetn       = 1'b0;
      start_i      = 1'b0;
      psum_valid_i = 1'b0;
      psum_i       = '0;
      out_ready_i  = 1'b1;
      bias_data_i  = '0;
      for (int i = 0; i < 2**AW; i++) bias_mem[i] = '0;
      #1;
      chk_reset_state("reset");
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk_reset_state("idle");

      // Directed pass: nominal, zero-sum with bias 0xFF, high and low saturation.
      for (int k = 0; k < 4; k++) begin
         ps[0][k] = 32'd4096;
         ps[1][k] = 32'd0;
         ps[2][k] = 32'd250000;
         ps[3][k] = -32'sd250000;
      end
      bias_mem[0] = 8'd0;
      bias_mem[1] = 8'd255;
      bias_mem[2] = 8'($urandom_range(0, 255));
      bias_mem[3] = 8'($urandom_range(0, 255));
      chk("model_t1", bqt(ps[0][0], ps[0][1], ps[0][2], ps[0][3], bias_mem[0]), 176);
      chk("model_t2", bqt(ps[1][0], ps[1][1], ps[1][2], ps[1][3], bias_mem[1]), 175);
      run_pass(-1, 1'b0);

      // Random pass with downstream stall on unit 1 and spurious start/psum traffic.
      randomize_units();
      run_pass(1, 1'b1);

      // Reset after two beats of unit 2, then a fresh pass must restart at index 0.
      randomize_units();
      d0 = done_cnt;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      run_unit(0, 1'b0, 1'b0);
      run_unit(1, 1'b0, 1'b0);
      send_beats(2, 2);
      #1 resetn = 1'b0;
      #1 chk_reset_state("midpass_reset");
      rd_q.delete();
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("no_done_after_reset", done_cnt - d0, 0);
      randomize_units();
      run_pass(3, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
